// File: rtl/pw_check_ctrl.sv
// Password-check initiator: keypad code entry, stored-password fetch, checker
// handshake, and the unlock / fail-count / lockout sequence that follows.
module pw_check_ctrl #(
  parameter int SLOT_W      = 2,
  parameter int MAX_FAIL    = 3,
  parameter int UNLOCK_CYC  = 500,
  parameter int LOCKOUT_CYC = 1000,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  input  logic [SLOT_W-1:0] user_sel,
  output logic [SLOT_W-1:0] rf_addr,
  input  logic [16:0]       rf_rdata,
  output logic [15:0]       chk_data1,
  output logic [15:0]       chk_data2,
  output logic              chk_start,
  input  logic              chk_finish,
  input  logic              chk_match,
  output logic              unlock,
  output logic              fail,
  output logic              locked_out,
  output logic [2:0]        digit_cnt,
  output logic              busy
);
  localparam int TMAX0 = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
  localparam int TMAX  = (TMAX0 > TIMEOUT_CYC) ? TMAX0 : TIMEOUT_CYC;
  localparam int TW    = $clog2(TMAX + 1);
  localparam int FW    = $clog2(MAX_FAIL + 1);

  typedef enum logic [2:0] {
    S_ENTRY, S_FETCH, S_SETUP, S_START, S_WAIT, S_UNLOCK, S_FAIL, S_LOCKOUT
  } state_t;

  state_t          state, state_n;
  logic [15:0]     code;
  logic [TW-1:0]   timer;
  logic [FW-1:0]   fail_cnt, fail_cnt_inc;
  logic            seen_low;
  logic            key_digit, key_enter, key_clear, fin_ok, back_to_entry;

  assign key_digit     = key_valid && (key_code <= 4'd9);
  assign key_enter     = key_valid && (key_code == 4'hA);
  assign key_clear     = key_valid && (key_code == 4'hB);
  // a finish level left over from the previous check must drop before it counts
  assign fin_ok        = chk_finish && seen_low;
  assign fail_cnt_inc  = (fail_cnt == FW'(MAX_FAIL)) ? fail_cnt : fail_cnt + 1'b1;
  assign back_to_entry = (state != S_ENTRY) && (state_n == S_ENTRY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_ENTRY;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_ENTRY:   if (key_enter && digit_cnt == 3'd4) state_n = S_FETCH;
      S_FETCH:   state_n = rf_rdata[16] ? S_SETUP : S_FAIL;
      S_SETUP:   state_n = S_START;
      S_START:   state_n = S_WAIT;
      // the START cycle counts toward the timeout window
      S_WAIT:    if (fin_ok)                                state_n = chk_match ? S_UNLOCK : S_FAIL;
                 else if (timer == TW'(TIMEOUT_CYC - 2))    state_n = S_FAIL;
      S_UNLOCK:  if (timer == TW'(UNLOCK_CYC - 1))          state_n = S_ENTRY;
      S_FAIL:    state_n = (fail_cnt_inc == FW'(MAX_FAIL)) ? S_LOCKOUT : S_ENTRY;
      S_LOCKOUT: if (timer == TW'(LOCKOUT_CYC - 1))         state_n = S_ENTRY;
      default:   state_n = S_ENTRY;
    endcase
  end

  always_comb begin
    chk_start  = 1'b0;
    unlock     = 1'b0;
    fail       = 1'b0;
    locked_out = 1'b0;
    busy       = (state != S_ENTRY);
    unique case (state)
      S_START:   chk_start  = 1'b1;
      S_UNLOCK:  unlock     = 1'b1;
      S_FAIL:    fail       = 1'b1;
      S_LOCKOUT: locked_out = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code      <= '0;
      digit_cnt <= '0;
      chk_data1 <= '0;
      chk_data2 <= '0;
      rf_addr   <= '0;
      timer     <= '0;
      fail_cnt  <= '0;
      seen_low  <= 1'b0;
    end else begin
      timer <= (state_n != state || state == S_ENTRY) ? '0 : timer + 1'b1;

      if (state == S_START)                    seen_low <= 1'b0;
      else if (state == S_WAIT && !chk_finish) seen_low <= 1'b1;

      if (back_to_entry) begin
        code      <= '0;
        digit_cnt <= '0;
        chk_data1 <= '0;
        chk_data2 <= '0;
      end else begin
        unique case (state)
          S_ENTRY: begin
            if (key_enter) begin
              if (digit_cnt == 3'd4) begin
                rf_addr   <= user_sel;
                chk_data1 <= code;
              end else begin
                code      <= '0;
                digit_cnt <= '0;
              end
            end else if (key_clear) begin
              code      <= '0;
              digit_cnt <= '0;
            end else if (key_digit && digit_cnt != 3'd4) begin
              code      <= {code[11:0], key_code};
              digit_cnt <= digit_cnt + 3'd1;
            end
          end
          S_FETCH: if (rf_rdata[16]) chk_data2 <= rf_rdata[15:0];
          default: ;
        endcase
      end

      if (state == S_UNLOCK || (state == S_LOCKOUT && state_n == S_ENTRY)) fail_cnt <= '0;
      else if (state == S_FAIL)                                            fail_cnt <= fail_cnt_inc;
    end
  end
endmodule

// File: tb/tb_pw_check_ctrl.sv
// Randomized bench for pw_check_ctrl: a keypad/checker driver plus an
// attempt-level model predicting outcome, event timing and fail-count state.
module tb_pw_check_ctrl;
  localparam int SLOT_W = 2, MAX_FAIL = 3, UNLOCK_CYC = 500, LOCKOUT_CYC = 1000, TIMEOUT_CYC = 16;

  logic              clk = 1'b0, rst;
  logic              key_valid;
  logic [3:0]        key_code;
  logic [SLOT_W-1:0] user_sel, rf_addr;
  logic [16:0]       rf_rdata;
  logic [15:0]       chk_data1, chk_data2;
  logic              chk_start, chk_finish, chk_match;
  logic              unlock, fail, locked_out, busy;
  logic [2:0]        digit_cnt;
  logic [16:0]       rf [4];

  int          n_cmp = 0, n_bad = 0;
  int          fail_cnt_m = 0, cnt_m = 0;
  logic [15:0] code_m = '0;

  pw_check_ctrl #(.SLOT_W(SLOT_W), .MAX_FAIL(MAX_FAIL), .UNLOCK_CYC(UNLOCK_CYC),
                  .LOCKOUT_CYC(LOCKOUT_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .user_sel(user_sel),
    .rf_addr(rf_addr), .rf_rdata(rf_rdata), .chk_data1(chk_data1), .chk_data2(chk_data2),
    .chk_start(chk_start), .chk_finish(chk_finish), .chk_match(chk_match), .unlock(unlock),
    .fail(fail), .locked_out(locked_out), .digit_cnt(digit_cnt), .busy(busy));

  assign rf_rdata = rf[rf_addr];
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // one keypress while idle; never used for an enter with four digits held
  task automatic press(input logic [3:0] k);
    key_valid = 1'b1; key_code = k;
    tick();
    key_valid = 1'b0;
    if (k <= 4'd9) begin
      if (cnt_m < 4) begin code_m = {code_m[11:0], k}; cnt_m++; end
    end else if (k == 4'hB || (k == 4'hA && cnt_m < 4)) begin
      code_m = '0; cnt_m = 0;
    end
    check("digit_cnt", 64'(digit_cnt), 64'(cnt_m));
    check("idle_busy", 64'(busy), 64'(0));
  endtask

  task automatic enter_code(input logic [15:0] c);
    int n;
    logic [3:0] k;
    n = $urandom_range(0, 5);
    for (int i = 0; i < n; i++) begin
      k = 4'($urandom);
      if (k == 4'hA && cnt_m == 4) k = 4'hB;
      if ($urandom_range(0, 2) == 0) tick();
      press(k);
    end
    press(4'hB);
    for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
  endtask

  // enter + full check sequence; finish seen in WAIT: 'stale' highs, 'low' lows, then high
  task automatic attempt(input int slot, input int stale, input int low, input bit never);
    bit          avail, ok, lock, cm;
    int          r, fin_obs, j;
    logic [15:0] pw;
    logic [4:0]  exp_v;
    avail = rf[slot][16];
    pw    = rf[slot][15:0];
    j     = stale + low;
    if (!avail) begin
      r = 2; ok = 1'b0;
    end else if (!never && j <= TIMEOUT_CYC - 2) begin
      r = 5 + j; ok = (pw == code_m);
    end else begin
      r = 3 + TIMEOUT_CYC; ok = 1'b0;
    end
    lock    = !ok && (fail_cnt_m + 1 == MAX_FAIL);
    fin_obs = ok ? r + UNLOCK_CYC : (lock ? r + 1 + LOCKOUT_CYC : r + 1);
    cm      = 1'b0;
    user_sel = SLOT_W'(slot); key_code = 4'hA; key_valid = 1'b1;
    for (int k = 1; k <= fin_obs; k++) begin
      tick();
      if (k == 1) check("rf_addr", 64'(rf_addr), 64'(slot));
      if (k == 3 && avail) begin
        check("chk_data1", 64'(chk_data1), 64'(code_m));
        check("chk_data2", 64'(chk_data2), 64'(pw));
        cm = (chk_data1 == chk_data2);
      end
      exp_v = {k < fin_obs, k == 3 && avail, ok && k >= r && k < r + UNLOCK_CYC,
               !ok && k == r, lock && k > r && k <= r + LOCKOUT_CYC};
      check("ctl", 64'({busy, chk_start, unlock, fail, locked_out}), 64'(exp_v));
      if (k >= 4 && avail) begin
        chk_finish = never ? 1'b0 : ((k - 4 < stale) ? 1'b1 : (k - 4 < j) ? 1'b0 : 1'b1);
        chk_match  = cm;
      end
      user_sel  = SLOT_W'($urandom);
      key_valid = (k < fin_obs) ? 1'($urandom_range(0, 1)) : 1'b0;
      key_code  = 4'($urandom);
    end
    check("end_cnt", 64'(digit_cnt), 64'(0));
    check("end_data", 64'({chk_data1, chk_data2}), 64'(0));
    if (ok || lock) fail_cnt_m = 0;
    else            fail_cnt_m++;
    code_m = '0; cnt_m = 0;
  endtask

  initial begin
    int slot;
    logic [15:0] c;
    rst = 1'b1; key_valid = 1'b0; key_code = '0; user_sel = '0;
    chk_finish = 1'b0; chk_match = 1'b0;
    rf[0] = 17'h1_1234; rf[1] = 17'h0_1234;
    rf[2] = {1'b1, rand_bcd()}; rf[3] = {1'b1, rand_bcd()};
    tick();
    check("reset", 64'({rf_addr, chk_data1, chk_data2, chk_start, unlock, fail, locked_out, digit_cnt, busy}), 64'(0));
    rst = 1'b0;
    tick();

    enter_code(16'h1234); attempt(0, 0, 2, 1'b0);                 // match -> unlock
    for (int i = 0; i < 3; i++) begin                             // three fails -> lockout
      enter_code(16'h9999); attempt(0, 0, 1, 1'b0);
    end
    enter_code(16'h1234); attempt(1, 0, 1, 1'b0);                 // slot unavailable
    enter_code(16'h1234); attempt(0, 3, 1, 1'b0);                 // stale finish ignored
    enter_code(16'h1234); attempt(0, 0, 0, 1'b1);                 // checker never finishes
    press(4'd1); press(4'd2); press(4'd3); press(4'hA);           // short enter, no fail

    enter_code(16'h5678);                                         // reset during WAIT
    user_sel = 2'd2; key_code = 4'hA; key_valid = 1'b1;
    tick(); key_valid = 1'b0;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1 check("rst_mid", 64'({rf_addr, chk_data1, chk_data2, chk_start, unlock, fail, locked_out, digit_cnt, busy}), 64'(0));
    tick(); rst = 1'b0;
    fail_cnt_m = 0; code_m = '0; cnt_m = 0;
    press(4'd7); press(4'd8); press(4'hB);                        // clear after two digits

    for (int n = 0; n < 12; n++) begin
      slot = $urandom_range(0, 3);
      c = $urandom_range(0, 1) ? rf[slot][15:0] : rand_bcd();
      enter_code(c);
      attempt(slot, $urandom_range(0, 3), $urandom_range(1, 8), $urandom_range(0, 7) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
